// File: rtl/cpu_run_ctrl_pkg.sv
// rtl/cpu_run_ctrl_pkg.sv - shared state encodings, page codes and LED page decode
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_EXEC = 2'd2,
        S_CAP  = 2'd3
    } state_t;

    localparam logic [2:0] PG_B0   = 3'd0;
    localparam logic [2:0] PG_B1   = 3'd1;
    localparam logic [2:0] PG_B2   = 3'd2;
    localparam logic [2:0] PG_B3   = 3'd3;
    localparam logic [2:0] PG_FLAG = 3'd4;
    localparam int         PAGE_CNT = 5;

    // snap layout is {OF, ZF, ALU_F[31:0]}
    function automatic logic [7:0] led_page(input logic [2:0] page, input logic [33:0] snap);
        case (page)
            PG_B0:   return snap[7:0];
            PG_B1:   return snap[15:8];
            PG_B2:   return snap[23:16];
            PG_B3:   return snap[31:24];
            PG_FLAG: return {6'b0, snap[33:32]};
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_btn_debounce.sv
// rtl/cpu_run_ctrl_btn_debounce.sv - button synchronizer, stability filter and rise pulse
module cpu_run_ctrl_btn_debounce #(
    parameter int DEB_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int CW = $clog2(DEB_CYC);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_db;
    logic          r_db_q;
    logic          r_pulse;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_db_q  <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            // any glitch back to the accepted level restarts the stability window
            if (r_sync2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEB_CYC - 1)) begin
                r_db  <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_db_q  <= r_db;
            r_pulse <= r_db & ~r_db_q;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/step sequencer, result capture and LED page display
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int DEB_CYC  = 1_000_000,
    parameter int RUN_DIV  = 25_000_000,
    parameter int SCAN_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_step,
    input  logic        sw_run,
    input  logic        sw_auto,
    input  logic [2:0]  SW,
    input  logic [31:0] ALU_F,
    input  logic        ZF,
    input  logic        OF,
    output logic        cpu_en,
    output logic        busy,
    output logic [7:0]  instr_cnt,
    output logic [7:0]  LED
);

    localparam int RW = $clog2(RUN_DIV);
    localparam int SW_W = $clog2(SCAN_DIV);

    logic            r_run_s1;
    logic            r_run_s2;
    logic            r_auto_s1;
    logic            r_auto_s2;
    state_t          r_state;
    logic            r_cpu_en;
    logic            r_busy;
    logic [7:0]      r_instr_cnt;
    logic [33:0]     r_snap;
    logic [RW-1:0]   r_run_cnt;
    logic [SW_W-1:0] r_scan_cnt;
    logic [2:0]      r_scan_page;
    logic            w_step_pulse;
    logic [2:0]      w_page;

    cpu_run_ctrl_btn_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_step_deb (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_step),
        .o_pulse (w_step_pulse)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run_s1  <= 1'b0;
            r_run_s2  <= 1'b0;
            r_auto_s1 <= 1'b0;
            r_auto_s2 <= 1'b0;
        end else begin
            r_run_s1  <= sw_run;
            r_run_s2  <= r_run_s1;
            r_auto_s1 <= sw_auto;
            r_auto_s2 <= r_auto_s1;
        end
    end

    // step pulses outside S_IDLE fall through every branch and are lost on purpose
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cpu_en    <= 1'b0;
            r_busy      <= 1'b0;
            r_run_cnt   <= '0;
            r_instr_cnt <= '0;
            r_snap      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_run_s2) begin
                        r_state <= S_RUN;
                    end else if (w_step_pulse) begin
                        r_state  <= S_EXEC;
                        r_cpu_en <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!r_run_s2) begin
                        r_state   <= S_IDLE;
                        r_run_cnt <= '0;
                    end else if (r_run_cnt == RW'(RUN_DIV - 1)) begin
                        r_state   <= S_EXEC;
                        r_run_cnt <= '0;
                        r_cpu_en  <= 1'b1;
                        r_busy    <= 1'b1;
                    end else begin
                        r_run_cnt <= r_run_cnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    r_state  <= S_CAP;
                    r_cpu_en <= 1'b0;
                end
                S_CAP: begin
                    r_snap      <= {OF, ZF, ALU_F};
                    r_instr_cnt <= r_instr_cnt + 8'd1;
                    r_busy      <= 1'b0;
                    r_state     <= r_run_s2 ? S_RUN : S_IDLE;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_cpu_en <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scan_cnt  <= '0;
            r_scan_page <= PG_B0;
        end else if (!r_auto_s2) begin
            r_scan_cnt  <= '0;
            r_scan_page <= PG_B0;
        end else if (r_scan_cnt == SW_W'(SCAN_DIV - 1)) begin
            r_scan_cnt  <= '0;
            r_scan_page <= (r_scan_page == 3'(PAGE_CNT - 1)) ? PG_B0 : r_scan_page + 3'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    assign w_page    = r_auto_s2 ? r_scan_page : SW;
    assign LED       = led_page(w_page, r_snap);
    assign cpu_en    = r_cpu_en;
    assign busy      = r_busy;
    assign instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - self-checking bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

    localparam int DEB = 4;
    localparam int RDIV = 8;
    localparam int SDIV = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_step;
    logic        sw_run;
    logic        sw_auto;
    logic [2:0]  sw;
    logic [31:0] alu_f;
    logic        zf;
    logic        of;
    logic        cpu_en;
    logic        busy;
    logic [7:0]  instr_cnt;
    logic [7:0]  led;

    cpu_run_ctrl #(
        .DEB_CYC  (DEB),
        .RUN_DIV  (RDIV),
        .SCAN_DIV (SDIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_step  (btn_step),
        .sw_run    (sw_run),
        .sw_auto   (sw_auto),
        .SW        (sw),
        .ALU_F     (alu_f),
        .ZF        (zf),
        .OF        (of),
        .cpu_en    (cpu_en),
        .busy      (busy),
        .instr_cnt (instr_cnt),
        .LED       (led)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        step;
        logic [31:0] alu;
        logic        zf;
        logic        of_;
        logic [2:0]  sw;
        logic [7:0]  led;
    } vec_t;

    vec_t        tbl[10];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          pulses = 0;
    int          pulse_q[$];
    logic [31:0] m_alu;
    logic        m_zf;
    logic        m_of;
    int          m_cnt;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cpu_en) begin
            pulses++;
            pulse_q.push_back(cyc);
        end
    endtask

    function automatic logic [7:0] model_led(input logic [2:0] pg);
        if (pg < 3'd4) return 8'(m_alu >> (8 * pg));
        if (pg == 3'd4) return {6'b0, m_of, m_zf};
        return 8'h00;
    endfunction

    task automatic press(input int hold);
        btn_step = 1'b1;
        repeat (hold) tick();
        btn_step = 1'b0;
        repeat (12) tick();
    endtask

    task automatic step_model(input logic [31:0] a, input logic z, input logic o);
        int p0;
        alu_f = a;
        zf = z;
        of = o;
        p0 = pulses;
        press(12);
        m_alu = a;
        m_zf = z;
        m_of = o;
        m_cnt++;
        check("step_one_pulse", 32'(pulses - p0), 32'd1);
        check("step_instr_cnt", 32'(instr_cnt), 32'(m_cnt & 255));
    endtask

    initial begin
        int   p0;
        logic found;

        rst = 1'b0; btn_step = 1'b0; sw_run = 1'b0; sw_auto = 1'b0;
        sw = 3'd0; alu_f = '0; zf = 1'b0; of = 1'b0;
        m_alu = '0; m_zf = 1'b0; m_of = 1'b0; m_cnt = 0;

        tbl[0] = '{1'b1, 32'h12345678, 1'b0, 1'b0, 3'd0, 8'h78};
        tbl[1] = '{1'b0, 32'h12345678, 1'b0, 1'b0, 3'd3, 8'h12};
        tbl[2] = '{1'b0, 32'h12345678, 1'b0, 1'b0, 3'd1, 8'h56};
        tbl[3] = '{1'b0, 32'h12345678, 1'b0, 1'b0, 3'd4, 8'h00};
        tbl[4] = '{1'b0, 32'h12345678, 1'b0, 1'b0, 3'd7, 8'h00};
        tbl[5] = '{1'b1, 32'h00000000, 1'b1, 1'b0, 3'd4, 8'h01};
        tbl[6] = '{1'b1, 32'h800000A5, 1'b1, 1'b1, 3'd4, 8'h03};
        tbl[7] = '{1'b0, 32'h800000A5, 1'b1, 1'b1, 3'd0, 8'hA5};
        tbl[8] = '{1'b0, 32'h800000A5, 1'b1, 1'b1, 3'd3, 8'h80};
        tbl[9] = '{1'b0, 32'h800000A5, 1'b1, 1'b1, 3'd5, 8'h00};

        repeat (3) tick();
        for (int p = 0; p < 8; p++) begin
            sw = 3'(p);
            tick();
            check("rst_led_held", 32'(led), 32'h0);
        end
        check("rst_cpu_en", 32'(cpu_en), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_instr", 32'(instr_cnt), 32'h0);
        rst = 1'b1;
        repeat (3) tick();
        for (int p = 0; p < 8; p++) begin
            sw = 3'(p);
            tick();
            check("rst_led_rel", 32'(led), 32'h0);
        end
        check("rel_cpu_en", 32'(cpu_en), 32'h0);
        check("rel_busy", 32'(busy), 32'h0);

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].step) step_model(tbl[i].alu, tbl[i].zf, tbl[i].of_);
            sw = tbl[i].sw;
            tick();
            check($sformatf("tbl_led[%0d]", i), 32'(led), 32'(tbl[i].led));
        end

        // latency: cpu_en, then CAP, then snapshot visible
        alu_f = 32'hA1B2C3D4; zf = 1'b0; of = 1'b0; sw = 3'd0;
        p0 = pulses;
        btn_step = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (cpu_en) found = 1'b1;
        end
        check("lat_en_seen", 32'(found), 32'h1);
        check("lat_busy_exec", 32'(busy), 32'h1);
        check("lat_led_old", 32'(led), 32'(model_led(3'd0)));
        tick();
        check("lat_en_one_cycle", 32'(cpu_en), 32'h0);
        check("lat_busy_cap", 32'(busy), 32'h1);
        check("lat_led_cap", 32'(led), 32'(model_led(3'd0)));
        tick();
        m_alu = alu_f; m_zf = zf; m_of = of; m_cnt++;
        check("lat_busy_done", 32'(busy), 32'h0);
        check("lat_led_new", 32'(led), 32'(model_led(3'd0)));
        check("lat_instr", 32'(instr_cnt), 32'(m_cnt & 255));
        repeat (10) tick();
        btn_step = 1'b0;
        repeat (12) tick();
        check("lat_no_repeat", 32'(pulses - p0), 32'd1);

        p0 = pulses;
        for (int i = 0; i < 4; i++) begin
            btn_step = 1'b1;
            repeat (2) tick();
            btn_step = 1'b0;
            tick();
        end
        repeat (12) tick();
        check("bounce_no_pulse", 32'(pulses - p0), 32'd0);
        check("bounce_instr", 32'(instr_cnt), 32'(m_cnt & 255));

        // free run with a step press held in the middle
        alu_f = 32'h0BADF00D; zf = 1'b0; of = 1'b0;
        pulse_q.delete();
        sw_run = 1'b1;
        for (int i = 1; i <= 55; i++) begin
            tick();
            if (i == 15) btn_step = 1'b1;
            if (i == 35) btn_step = 1'b0;
        end
        sw_run = 1'b0;
        repeat (30) tick();
        check("run_pulse_count", 32'(pulse_q.size()), 32'd5);
        for (int i = 1; i < pulse_q.size(); i++)
            check("run_spacing", 32'(pulse_q[i] - pulse_q[i-1]), 32'(RDIV + 2));
        m_alu = alu_f; m_zf = zf; m_of = of; m_cnt += 5;
        check("run_instr", 32'(instr_cnt), 32'(m_cnt & 255));
        sw = 3'd2;
        tick();
        check("run_snap", 32'(led), 32'(model_led(3'd2)));

        step_model(32'h0, 1'b1, 1'b0);
        sw = 3'd0;
        sw_auto = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (led == 8'h01) found = 1'b1;
        end
        check("scan_flag_seen", 32'(found), 32'h1);
        for (int k = 0; k < 30; k++) begin
            check("scan_flag_seq", 32'(led), ((k / SDIV) % 5 == 0) ? 32'h1 : 32'h0);
            tick();
        end
        sw_auto = 1'b0;
        repeat (3) tick();
        sw = 3'd4;
        tick();
        check("manual_after_scan", 32'(led), 32'h01);

        for (int r = 0; r < 10; r++) begin
            step_model($urandom, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            for (int p = 0; p < 8; p++) begin
                sw = 3'(p);
                tick();
                check("rand_led", 32'(led), 32'(model_led(3'(p))));
            end
        end

        step_model(32'h44332211, 1'b0, 1'b1);
        sw = 3'd7;
        tick();
        sw_auto = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (led != 8'h00) found = 1'b1;
        end
        check("scan_seen", 32'(found), 32'h1);
        for (int k = 0; k < 30; k++) begin
            check("scan_seq", 32'(led), 32'(model_led(3'((k / SDIV) % 5))));
            tick();
        end
        sw_auto = 1'b0;
        repeat (4) tick();
        check("scan_off_manual", 32'(led), 32'h0);

        // long free run to cross the 255->0 wrap
        p0 = pulses;
        alu_f = 32'hCAFEF00D;
        sw_run = 1'b1;
        repeat (2595) tick();
        sw_run = 1'b0;
        repeat (20) tick();
        check("wrap_enough", 32'(pulses - p0 >= 256), 32'h1);
        m_cnt += pulses - p0;
        m_alu = alu_f; m_zf = zf; m_of = of;
        check("wrap_instr", 32'(instr_cnt), 32'(m_cnt & 255));
        sw = 3'd1;
        tick();
        check("wrap_snap", 32'(led), 32'(model_led(3'd1)));

        // async reset while cpu_en is high
        alu_f = 32'hDEADBEEF;
        sw = 3'd0;
        btn_step = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (cpu_en) found = 1'b1;
        end
        check("mid_en_seen", 32'(found), 32'h1);
        rst = 1'b0;
        #1;
        check("mid_cpu_en_drop", 32'(cpu_en), 32'h0);
        check("mid_busy", 32'(busy), 32'h0);
        check("mid_instr", 32'(instr_cnt), 32'h0);
        check("mid_led", 32'(led), 32'h0);
        btn_step = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        m_alu = '0; m_zf = 1'b0; m_of = 1'b0; m_cnt = 0;
        repeat (12) tick();
        check("mid_no_capture", 32'(led), 32'h0);
        check("mid_idle_en", 32'(cpu_en), 32'h0);
        step_model(32'h000000AB, 1'b0, 1'b0);
        sw = 3'd0;
        tick();
        check("mid_resume_led", 32'(led), 32'hAB);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
